bus_firewall_mr: RTL
====================

Name: bus_firewall_mr

Overview:
- Multi-region, multi-master bus firewall; successor to the single-range firewall check, generalised to NUM_REGIONS programmable ranges.
- Each region has a per-master ID allow-mask, a minimum privilege, R/W permissions and a lock bit.
- Sits between interconnect and a protected target. Registers a one-cycle allow/block decision and pushes every blocked transaction into a violation log FIFO that raises an interrupt.

Parameters:
- ADDR_WIDTH, 32, transaction/region address width
- NUM_REGIONS, 8, programmable regions (1..16)
- ID_WIDTH, 4, master ID width; allow-mask is 2**ID_WIDTH bits
- LOG_DEPTH, 4, violation FIFO entries (power of two, >=2)
- DEFAULT_ALLOW, 0, decision when no enabled region matches

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  region config write strobe (always accepted)
- cfg_region  in  $clog2(NUM_REGIONS)  target region index
- cfg_base  in  ADDR_WIDTH  region base, inclusive
- cfg_limit  in  ADDR_WIDTH  region limit, inclusive
- cfg_id_mask  in  2**ID_WIDTH  allowed master IDs
- cfg_min_priv  in  2  minimum privilege
- cfg_perm  in  2  {W,R} permission bits
- cfg_enable  in  1  region enable
- cfg_lock  in  1  lock region until reset
- cfg_err  out  1  one-cycle pulse: write to locked region was rejected
- txn_valid / txn_ready  in/out  1  inbound handshake
- txn_addr  in  ADDR_WIDTH  address
- txn_id  in  ID_WIDTH  master ID
- txn_priv  in  2  requester privilege
- txn_write  in  1  1=write, 0=read
- out_valid / out_ready  out/in  1  outbound handshake
- out_addr, out_id, out_write  out  as inbound  registered pass-through
- out_blocked  out  1  1 = denied; downstream returns error, target is not accessed
- log_valid / log_ready  out/in  1  violation FIFO pop handshake
- log_addr, log_id, log_write  out  as inbound  oldest violation
- log_region  out  $clog2(NUM_REGIONS)+1  matched region index; MSB=1 means no match
- log_overflow  out  1  sticky: a violation was dropped
- log_clr  in  1  clears log_overflow
- irq  out  1  log_valid | log_overflow

Behaviour:
- Reset: all regions disabled and unlocked, all fields 0. out_valid=0, out_blocked=0, cfg_err=0, FIFO empty (log_valid=0), log_overflow=0, irq=0. Reset mid-transaction discards the in-flight beat.
- Config write:
  - On cfg_valid, if region[cfg_region] is unlocked: all fields load next cycle, and lock is set if cfg_lock=1.
  - If the region is locked: no field changes and cfg_err pulses 1 cycle later.
  - The lock bit clears only on rst.
- Match: region i matches when enable && base <= addr <= limit, unsigned full-width compare.
  - base > limit means the region never matches.
  - If several regions match, the lowest index wins.
- Allow requires all of:
  - id_mask[txn_id] is set;
  - txn_priv >= min_priv;
  - perm[W] set for a write, or perm[R] set for a read.
- No match: allow = DEFAULT_ALLOW, and log_region MSB is set.
- Pipeline:
  - txn_ready = !out_valid || out_ready.
  - An accepted beat appears on out_* the next cycle; latency is exactly 1.
  - out_* are held stable while out_valid && !out_ready.
- Config/traffic collision: a beat accepted in the same cycle as a config write is judged with the old config. The new config applies from the next accepted beat.
- Logging: when a beat is accepted and denied, push it into the FIFO in the same cycle.
  - If the FIFO is full, the entry is dropped and log_overflow sets; a simultaneous pop does not free space for that push.
  - Pop when log_valid && log_ready.
  - FIFO pointers wrap modulo LOG_DEPTH, with a count register 0..LOG_DEPTH.
- log_clr and an overflowing push in the same cycle: overflow stays set.
- irq is registered-output derived, with no combinational path from txn_*.

Optional Feature:
- Macro: FW_STATS_EN.
- Defined: adds a read port stat_region (in, $clog2(NUM_REGIONS)) and stat_count (out, 16, combinational read).
  - Per-region 16-bit saturating violation counters; unmatched violations are not counted.
  - Counters increment on every denied beat, including dropped log entries.
  - Counters hold at 16'hFFFF and clear on rst only.
- Undefined: no counters and no stat ports. Behaviour is otherwise identical.

Decomposition:
- Package fw_mr_pkg: region_cfg_t struct {base, limit, id_mask, min_priv, perm, enable, lock}, log_entry_t struct, PERM_R/PERM_W bit constants.
- Sub-module fw_log_fifo: parametrised synchronous FIFO holding log_entry_t, with full/empty/count outputs.
- Region match and priority encode stay inline.

Test Plan:
- Region0 base=0x1000, limit=0x1FFF, mask=0x0004, perm=RW, priv=0. Read addr 0x1800 id=2 -> out_blocked=0 after 1 cycle. Same read with id=3 -> out_blocked=1, log entry {0x1800, 3, region 0}, irq=1.
- Region0 and Region1 overlap at 0x1000. Region0 denies the write, Region1 allows it. Write to 0x1000 -> blocked (priority to region 0, lowest index).
- Configure region2 with cfg_lock=1, then rewrite region2 with a new base -> cfg_err pulse and base unchanged. After rst, the rewrite succeeds.
- LOG_DEPTH=4, log_ready=0, 6 denied beats -> 4 entries held, log_overflow=1. Pop all 4 and pulse log_clr -> irq=0.
- Hold out_ready=0 for 3 cycles with txn_valid=1 -> txn_ready=0 and out_* held stable. Release -> 1 beat per cycle.
- With FW_STATS_EN: 70000 denied hits on region1 -> stat_count saturates at 0xFFFF.

Source files
------------

// File: rtl/fw_mr_pkg.sv
// Shared types for the multi-region bus firewall.
// The struct field widths follow the package widths below. The top-level
// parameters default to the same values, so change both together.
// Optional feature macro used by the block: FW_STATS_EN.
package fw_mr_pkg;
  localparam int FW_ADDR_W      = 32;
  localparam int FW_ID_W        = 4;
  localparam int FW_NUM_REGIONS = 8;
  localparam int FW_RIDX_W      = $clog2(FW_NUM_REGIONS);

  // bit positions inside the {W,R} permission field
  localparam int PERM_R = 0;
  localparam int PERM_W = 1;

  typedef struct packed {
    logic [FW_ADDR_W-1:0]   base;
    logic [FW_ADDR_W-1:0]   limit;
    logic [2**FW_ID_W-1:0]  id_mask;
    logic [1:0]             min_priv;
    logic [1:0]             perm;
    logic                   enable;
    logic                   lock;
  } region_cfg_t;

  // region MSB set = no enabled region matched
  typedef struct packed {
    logic [FW_ADDR_W-1:0] addr;
    logic [FW_ID_W-1:0]   id;
    logic                 write;
    logic [FW_RIDX_W:0]   region;
  } log_entry_t;
endpackage

// File: rtl/bus_firewall_mr_if.sv
// Bus bundle for bus_firewall_mr: config, inbound, outbound and log ports.
// The stat_* read port exists only when FW_STATS_EN is defined.
interface bus_firewall_mr_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int NUM_REGIONS = 8
);
  localparam int RIDX_W = $clog2(NUM_REGIONS);

  logic                   cfg_valid;
  logic [RIDX_W-1:0]      cfg_region;
  logic [ADDR_WIDTH-1:0]  cfg_base;
  logic [ADDR_WIDTH-1:0]  cfg_limit;
  logic [2**ID_WIDTH-1:0] cfg_id_mask;
  logic [1:0]             cfg_min_priv;
  logic [1:0]             cfg_perm;
  logic                   cfg_enable;
  logic                   cfg_lock;
  logic                   cfg_err;

  logic                   txn_valid;
  logic                   txn_ready;
  logic [ADDR_WIDTH-1:0]  txn_addr;
  logic [ID_WIDTH-1:0]    txn_id;
  logic [1:0]             txn_priv;
  logic                   txn_write;

  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_WIDTH-1:0]  out_addr;
  logic [ID_WIDTH-1:0]    out_id;
  logic                   out_write;
  logic                   out_blocked;

  logic                   log_valid;
  logic                   log_ready;
  logic [ADDR_WIDTH-1:0]  log_addr;
  logic [ID_WIDTH-1:0]    log_id;
  logic                   log_write;
  logic [RIDX_W:0]        log_region;
  logic                   log_overflow;
  logic                   log_clr;
  logic                   irq;

`ifdef FW_STATS_EN
  logic [RIDX_W-1:0]      stat_region;
  logic [15:0]            stat_count;
`endif

  modport slave (
`ifdef FW_STATS_EN
    input  stat_region,
    output stat_count,
`endif
    input  cfg_valid, cfg_region, cfg_base, cfg_limit, cfg_id_mask,
           cfg_min_priv, cfg_perm, cfg_enable, cfg_lock,
    output cfg_err,
    input  txn_valid, txn_addr, txn_id, txn_priv, txn_write,
    output txn_ready,
    output out_valid, out_addr, out_id, out_write, out_blocked,
    input  out_ready,
    output log_valid, log_addr, log_id, log_write, log_region,
           log_overflow, irq,
    input  log_ready, log_clr
  );

  modport master (
`ifdef FW_STATS_EN
    output stat_region,
    input  stat_count,
`endif
    output cfg_valid, cfg_region, cfg_base, cfg_limit, cfg_id_mask,
           cfg_min_priv, cfg_perm, cfg_enable, cfg_lock,
    input  cfg_err,
    output txn_valid, txn_addr, txn_id, txn_priv, txn_write,
    input  txn_ready,
    input  out_valid, out_addr, out_id, out_write, out_blocked,
    output out_ready,
    input  log_valid, log_addr, log_id, log_write, log_region,
           log_overflow, irq,
    output log_ready, log_clr
  );
endinterface

// File: rtl/fw_log_fifo.sv
// Violation log FIFO. A push into a full FIFO is dropped even when a pop
// happens in the same cycle, so the caller can flag overflow from full alone.
module fw_log_fifo
  import fw_mr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  log_entry_t wdata,
  input  logic       pop,
  output log_entry_t rdata,
  output logic       full,
  output logic       empty,
  output logic [CW-1:0] count
);
  log_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bus_firewall_mr.sv
// Multi-region, multi-master bus firewall. Each beat is matched against the
// programmable regions (lowest index wins), judged against that region's ID
// mask, privilege floor and R/W permission, and forwarded one cycle later
// with a blocked flag. Denied beats are pushed into a violation log FIFO.
// Optional macro FW_STATS_EN adds per-region saturating violation counters.
module bus_firewall_mr
  import fw_mr_pkg::*;
#(
  parameter int ADDR_WIDTH    = FW_ADDR_W,
  parameter int NUM_REGIONS   = FW_NUM_REGIONS,
  parameter int ID_WIDTH      = FW_ID_W,
  parameter int LOG_DEPTH     = 4,
  parameter int DEFAULT_ALLOW = 0
) (
  input logic clk,
  input logic rst,
  bus_firewall_mr_if.slave bus
);
  localparam int RIDX_W = $clog2(NUM_REGIONS);
  localparam int CNT_W  = $clog2(LOG_DEPTH + 1);

  region_cfg_t            cfg_q [NUM_REGIONS];
  logic                   cfg_err_q;
  logic                   cfg_idx_ok;

  logic [NUM_REGIONS-1:0] match;
  logic                   hit;
  logic [RIDX_W-1:0]      hit_idx;
  logic                   perm_ok;
  logic                   allow;
  logic                   txn_ready;
  logic                   accept;
  logic                   push;

  logic                   out_valid_q;
  logic                   out_blocked_q;
  logic [ADDR_WIDTH-1:0]  out_addr_q;
  logic [ID_WIDTH-1:0]    out_id_q;
  logic                   out_write_q;

  log_entry_t             push_entry, head_entry;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   overflow_q;

  assign cfg_idx_ok = (int'(bus.cfg_region) < NUM_REGIONS);

  // region config writes; a locked region rejects writes until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) cfg_q[i] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (bus.cfg_valid && cfg_idx_ok) begin
        if (cfg_q[bus.cfg_region].lock) begin
          cfg_err_q <= 1'b1;
        end else begin
          cfg_q[bus.cfg_region] <= '{base:     bus.cfg_base,
                                     limit:    bus.cfg_limit,
                                     id_mask:  bus.cfg_id_mask,
                                     min_priv: bus.cfg_min_priv,
                                     perm:     bus.cfg_perm,
                                     enable:   bus.cfg_enable,
                                     lock:     bus.cfg_lock};
        end
      end
    end
  end

  // per-region range match; base > limit can never satisfy both compares
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++)
      match[i] = cfg_q[i].enable && (bus.txn_addr >= cfg_q[i].base) &&
                 (bus.txn_addr <= cfg_q[i].limit);
  end

  // priority encode: scanning downward leaves the lowest matching index
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = RIDX_W'(i);
      end
    end
  end

  // allow decision against the winning region, or the default on a miss
  always_comb begin
    perm_ok = bus.txn_write ? cfg_q[hit_idx].perm[PERM_W] : cfg_q[hit_idx].perm[PERM_R];
    if (hit)
      allow = cfg_q[hit_idx].id_mask[bus.txn_id] &&
              (bus.txn_priv >= cfg_q[hit_idx].min_priv) && perm_ok;
    else
      allow = (DEFAULT_ALLOW != 0);
  end

  assign txn_ready = !out_valid_q || bus.out_ready;
  assign accept    = bus.txn_valid && txn_ready;
  assign push      = accept && !allow;

  // one-stage output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_blocked_q <= 1'b0;
      out_addr_q    <= '0;
      out_id_q      <= '0;
      out_write_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_blocked_q <= !allow;
      out_addr_q    <= bus.txn_addr;
      out_id_q      <= bus.txn_id;
      out_write_q   <= bus.txn_write;
    end else if (bus.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign push_entry = '{addr:   bus.txn_addr,
                        id:     bus.txn_id,
                        write:  bus.txn_write,
                        region: {!hit, hit_idx}};

  fw_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (bus.log_ready),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // sticky overflow; a dropped push wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                    overflow_q <= 1'b0;
    else if (push && fifo_full) overflow_q <= 1'b1;
    else if (bus.log_clr)       overflow_q <= 1'b0;
  end

  assign bus.cfg_err      = cfg_err_q;
  assign bus.txn_ready    = txn_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_blocked  = out_blocked_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.out_id       = out_id_q;
  assign bus.out_write    = out_write_q;
  assign bus.log_valid    = (fifo_count != '0);
  assign bus.log_addr     = head_entry.addr;
  assign bus.log_id       = head_entry.id;
  assign bus.log_write    = head_entry.write;
  assign bus.log_region   = head_entry.region;
  assign bus.log_overflow = overflow_q;
  assign bus.irq          = !fifo_empty || overflow_q;

`ifdef FW_STATS_EN
  logic [15:0] stat_q [NUM_REGIONS];

  // saturating per-region violation counters; misses are not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) stat_q[i] <= '0;
    end else if (push && hit && (stat_q[hit_idx] != 16'hFFFF)) begin
      stat_q[hit_idx] <= stat_q[hit_idx] + 16'd1;
    end
  end

  assign bus.stat_count = stat_q[bus.stat_region];
`endif
endmodule
